// File: rtl/rf_pkg.sv
// Shared defaults and the address-width helper for the register file.
// Latency: not applicable (constants and functions only).
// Backpressure: not applicable.
package rf_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int NUM_REGS_DEF = 4;
  localparam int ZERO_REG_DEF = 1;

  // Address width for a given register count; never below one bit.
  function automatic int addr_w(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bundle of the scoreboarded register file.
// Latency: wires only; reads and hazard flags are combinational at the slave.
// Backpressure: none, every strobe is taken in the cycle it is presented.
interface regfile_sb_if
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
);
  localparam int ADDR_W = addr_w(NUM_REGS);

  // Operand reads
  logic [ADDR_W-1:0] RS;
  logic [ADDR_W-1:0] RT;
  logic [DATA_W-1:0] ReadRS;
  logic [DATA_W-1:0] ReadRT;
  logic              RSBusy;
  logic              RTBusy;
  // Writeback
  logic              RegWrite;
  logic [ADDR_W-1:0] RD;
  logic [DATA_W-1:0] WriteData;
  // Reservation
  logic              Reserve;
  logic [ADDR_W-1:0] ReserveRD;
  logic              WawHazard;
  logic [ADDR_W:0]   BusyCount;

  modport master (
    output RS, RT, RegWrite, RD, WriteData, Reserve, ReserveRD,
    input  ReadRS, ReadRT, RSBusy, RTBusy, WawHazard, BusyCount
  );

  modport slave (
    input  RS, RT, RegWrite, RD, WriteData, Reserve, ReserveRD,
    output ReadRS, ReadRT, RSBusy, RTBusy, WawHazard, BusyCount
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy bits with set-over-clear priority and a registered busy population count.
// Latency: busy bits and count update one edge after the set/clear strobes.
// Backpressure: none; set and clear are accepted every cycle.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int  NUM_REGS = NUM_REGS_DEF,
  parameter int  ZERO_REG = ZERO_REG_DEF,
  localparam int ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                i_clr_vld,
  input  logic [ADDR_W-1:0]   i_clr_addr,
  input  logic                i_set_vld,
  input  logic [ADDR_W-1:0]   i_set_addr,
  output logic [NUM_REGS-1:0] o_busy,
  output logic [ADDR_W:0]     o_busy_cnt
);

  logic [NUM_REGS-1:0] r_busy;
  logic [ADDR_W:0]     r_busy_cnt;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [ADDR_W:0]     w_busy_cnt_nxt;

  // Next busy vector: clear first so a same-register reservation overrides the completing write.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_vld) w_busy_nxt[i_clr_addr] = 1'b0;
    if (i_set_vld) w_busy_nxt[i_set_addr] = 1'b1;
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
    w_busy_cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_busy_cnt_nxt = w_busy_cnt_nxt + (ADDR_W+1)'(w_busy_nxt[i]);
    end
  end

  // Busy vector and its count are registered together so they always agree.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_busy_cnt_nxt;
    end
  end

  assign o_busy     = r_busy;
  assign o_busy_cnt = r_busy_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Register file with write-first bypass, optional hardwired-zero R0 and a busy scoreboard.
// Latency: reads, busy flags and WAW flag combinational; array and BusyCount update on the edge.
// Backpressure: none; writes and reservations are accepted in the cycle presented.
module regfile_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic         Clock,
  input  logic         Reset_n,
  regfile_sb_if.slave  bus
);

  localparam int ADDR_W = addr_w(NUM_REGS);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic                w_wr_en;
  logic                w_rs_hit;
  logic                w_rt_hit;
  logic                w_rsv_hit;
  logic [NUM_REGS-1:0] w_busy;
  logic [ADDR_W:0]     w_busy_cnt;

  // Writes to the hardwired-zero register are dropped, including from the bypass.
  assign w_wr_en   = bus.RegWrite && !((ZERO_REG != 0) && (bus.RD == '0));
  assign w_rs_hit  = bus.RegWrite && (bus.RD == bus.RS);
  assign w_rt_hit  = bus.RegWrite && (bus.RD == bus.RT);
  assign w_rsv_hit = bus.RegWrite && (bus.RD == bus.ReserveRD);

  // Data array; register 0 is never written when hardwired to zero, so it stays at its reset value.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[bus.RD] <= bus.WriteData;
    end
  end

  // Operand muxes: same-cycle writeback data wins over the stored value.
  always_comb begin
    bus.ReadRS = r_regs[bus.RS];
    bus.ReadRT = r_regs[bus.RT];
    if (w_wr_en && (bus.RD == bus.RS)) bus.ReadRS = bus.WriteData;
    if (w_wr_en && (bus.RD == bus.RT)) bus.ReadRT = bus.WriteData;
    if ((ZERO_REG != 0) && (bus.RS == '0)) bus.ReadRS = '0;
    if ((ZERO_REG != 0) && (bus.RT == '0)) bus.ReadRT = '0;
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .i_clr_vld  (bus.RegWrite),
    .i_clr_addr (bus.RD),
    .i_set_vld  (bus.Reserve),
    .i_set_addr (bus.ReserveRD),
    .o_busy     (w_busy),
    .o_busy_cnt (w_busy_cnt)
  );

  // A value arriving through the bypass this cycle is not a hazard for the reader.
  assign bus.RSBusy    = w_busy[bus.RS] && !w_rs_hit;
  assign bus.RTBusy    = w_busy[bus.RT] && !w_rt_hit;
  assign bus.WawHazard = bus.Reserve && w_busy[bus.ReserveRD] && !w_rsv_hit;
  assign bus.BusyCount = w_busy_cnt;

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the 2-bit-addressed, 16-bit register file: configurable width and depth, optional hardwired-zero register 0, write-first read bypass, and a per-register busy scoreboard for in-flight results. Sits between decode (issues reservations, reads operands) and writeback (commits results). It replaces the fixed 4×16 file in the 16-bit CPU datapath.

## Interface
- DATA_W, 16, register width in bits
- NUM_REGS, 4, number of registers; power of two, at least 2
- ZERO_REG, 1, when 1, register 0 reads 0 and ignores writes and reservations
- ADDR_W, $clog2(NUM_REGS), derived; not to be overridden

Ports:
- Clock  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- RS  in  ADDR_W  read port A address
- RT  in  ADDR_W  read port B address
- ReadRS  out  DATA_W  port A data (combinational)
- ReadRT  out  DATA_W  port B data (combinational)
- RSBusy  out  1  port A register awaits writeback
- RTBusy  out  1  port B register awaits writeback
- RegWrite  in  1  writeback strobe
- RD  in  ADDR_W  writeback address
- WriteData  in  DATA_W  writeback data
- Reserve  in  1  decode claims a register as pending destination
- ReserveRD  in  ADDR_W  register being claimed
- WawHazard  out  1  Reserve targets an already-busy register (combinational)
- BusyCount  out  ADDR_W+1  number of busy registers (registered)

## Operation
- Reset (Reset_n low, any time, independent of Clock):
  - All registers go to 0.
  - All busy bits go to 0.
  - BusyCount goes to 0.
  - Consequently ReadRS, ReadRT, RSBusy, RTBusy and WawHazard read 0.
- Write: at a rising edge with RegWrite=1, Registers[RD] <= WriteData. Suppressed when ZERO_REG=1 and RD=0.
- Read: ReadRS = Registers[RS]. If RegWrite=1, RD=RS, and the write is not suppressed, ReadRS = WriteData (write-first bypass). RT is identical. ZERO_REG=1 with RS=0 always yields 0.
- Scoreboard, one busy bit per register, updated at a rising edge:
  - RegWrite clears busy[RD].
  - Reserve sets busy[ReserveRD].
  - If both act on the same register in the same cycle, set wins: a new producer supersedes the completing one.
  - ZERO_REG=1: register 0 never becomes busy.
- RSBusy = busy[RS] AND NOT (RegWrite=1 AND RD=RS). A value delivered by bypass is not a hazard. RTBusy is identical.
- WawHazard = Reserve AND busy[ReserveRD] AND NOT (RegWrite AND RD=ReserveRD). This is advisory only; the reservation still takes effect.
- BusyCount equals the population count of the next-state busy vector, so it is registered and consistent with busy after each edge.
  - Range: 0 to NUM_REGS-1 when ZERO_REG=1; 0 to NUM_REGS when ZERO_REG=0.
- A writeback to a non-busy register is legal: the data is written and busy stays 0.

## Timing
- Read latency 0: reads are combinational, and the bypass path runs combinationally from WriteData.
- A write becomes visible through the array one edge after the strobe, and through bypass in the same cycle.
- A reservation raises RSBusy/RTBusy in the cycle after the edge that samples Reserve.
- Reset asserted mid-cycle clears state immediately.
- On deassertion, the first rising edge with Reset_n high is the first functional edge.
- No input handshake: every strobe is accepted in the cycle presented.

## Structure
- Package rf_pkg holds the default DATA_W, NUM_REGS and ZERO_REG values, plus a function for the address width.
- Sub-module rf_scoreboard holds the busy vector, the set/clear priority, and the BusyCount popcount register.
- The top level holds the data array, the bypass muxes, and the hazard-masking logic.

## Test plan
- Reset, then pulse Reset_n low mid-run after writing 5 to R3 -> all reads 0, BusyCount=0, busy bits clear, before the next edge.
- Write 5 to R3 and 7 to R2 on consecutive edges, then RS=3, RT=2 -> ReadRS=5, ReadRT=7.
- RegWrite with RD=1, WriteData=0x00AB, while RS=1 in the same cycle -> ReadRS=0x00AB before the edge. With ZERO_REG=1, RD=0, WriteData=9 -> ReadRS at RS=0 stays 0 before and after the edge.
- Reserve R2 -> next cycle RS=2 gives RSBusy=1 and BusyCount=1. Writeback R2 with RS=2 -> RSBusy=0 that cycle, and BusyCount=0 after the edge.
- Reserve R1 while R1 is already busy -> WawHazard=1. Simultaneous Reserve R1 and RegWrite R1 -> WawHazard=0 and R1 remains busy after the edge.
- NUM_REGS=16, DATA_W=32, ZERO_REG=0 -> write 0xDEADBEEF to R15 and R0 and read both back; reserve all 16 -> BusyCount=16.
